// File: rtl/imem_loader.sv
// Instruction memory writer: takes a byte stream made of a 16-bit little-endian word count N
// followed by N little-endian 32-bit words, and writes those words to addresses 0..N-1.
module imem_loader #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [31:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, FIN} state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state;
  logic [15:0] count;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_word;
  logic        xfer;

  assign xfer = in_valid && in_ready;

  // waddr doubles as the word counter; on the last word it is left unchanged so it never wraps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      byte_cnt <= '0;
      asm_word <= '0;
      in_ready <= 1'b0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            error    <= 1'b0;
            waddr    <= '0;
            byte_cnt <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            state    <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            count[7:0] <= in_data;
            state      <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            count[15:8] <= in_data;
            if ({in_data, count[7:0]} == 16'd0 || {1'b0, in_data, count[7:0]} > DEPTH_L) begin
              error    <= ({in_data, count[7:0]} != 16'd0);
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= FIN;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            asm_word <= {in_data, asm_word[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              we       <= 1'b1;
              wdata    <= {in_data, asm_word[31:8]};
              in_ready <= 1'b0;
              state    <= WRITE;
            end
          end
        end
        WRITE: begin
          if (16'(waddr) == count - 16'd1) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            waddr    <= waddr + ADDR_WIDTH'(1);
            in_ready <= 1'b1;
            state    <= DATA;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven and
// popped by a negedge monitor whenever the loader pulses we.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        we;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(.DEPTH(256), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          last_we_cyc = 0;
  int          done_cnt = 0;
  bit          done_ok = 1'b0;
  bit          exp_err = 1'b0;
  bit          exp_wr = 1'b0;
  logic [31:0] words[2] = '{32'h00100513, 32'h00200593};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (we) begin
      if (sb.size() == 0) begin
        check("we_unexpected", 32'(we), 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("waddr", 32'(waddr), 32'(e.addr));
        check("wdata", wdata, e.data);
        check("we_latency", 32'(cyc), 32'(accept_cyc + 1));
      end
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      if (!done_ok) begin
        check("done_unexpected", 32'(done), 32'd0);
      end else begin
        check("done_error", 32'(error), 32'(exp_err));
        check("done_busy", 32'(busy), 32'd0);
        check("done_pending", 32'(sb.size()), 32'd0);
        check("done_latency", 32'(cyc), 32'(exp_wr ? last_we_cyc + 1 : accept_cyc + 1));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte's accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("byte_timeout", 32'(in_ready), 32'd1);
      return;
    end
    @(negedge clk);
    accept_cyc = cyc - 1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_in_ready", 32'(in_ready), 32'd1);
    check("start_error_clr", 32'(error), 32'd0);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 100 && done_cnt == d0; i++) @(negedge clk);
    if (done_cnt == d0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic load(input int n, input bit gaps, input bit start_mid, input bit start_at_done);
    int d0;
    int nd;
    logic [15:0] hdr;
    logic [31:0] w;
    d0      = done_cnt;
    exp_err = (n > 256);
    nd      = exp_err ? 0 : n;
    exp_wr  = (nd > 0);
    done_ok = 1'b1;
    hdr     = 16'(n);
    start_pulse();
    send_byte(hdr[7:0]);
    send_byte(hdr[15:8]);
    for (int i = 0; i < nd; i++) begin
      int pos;
      w = words[i];
      sb.push_back('{addr: 8'(i), data: w});
      pos = $urandom_range(1, 3);
      for (int b = 0; b < 4; b++) begin
        if (gaps && b == pos) idle(3);
        if (start_mid && i == 0 && b == 1) start = 1'b1;
        send_byte(w[8*b +: 8]);
        start = 1'b0;
      end
    end
    in_valid = 1'b0;
    if (start_at_done) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_at_done_busy", 32'(busy), 32'd0);
      check("start_at_done_ready", 32'(in_ready), 32'd0);
    end
    wait_done(d0);
    idle(2);
    check("post_busy", 32'(busy), 32'd0);
    check("post_error", 32'(error), 32'(exp_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_waddr"}, 32'(waddr), 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    idle(2);
    check_reset_outputs("idle");

    load(2, 1'b0, 1'b0, 1'b0);
    load(2, 1'b1, 1'b0, 1'b0);
    load(0, 1'b0, 1'b0, 1'b0);
    load(257, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("error_sticky", 32'(error), 32'd1);
    load(2, 1'b0, 1'b1, 1'b1);

    // Abort after the second word's second byte; word 1 must never be written.
    done_ok = 1'b0;
    start_pulse();
    send_byte(8'h02);
    send_byte(8'h00);
    sb.push_back('{addr: 8'd0, data: words[0]});
    for (int b = 0; b < 4; b++) send_byte(words[0][8*b +: 8]);
    send_byte(words[1][7:0]);
    send_byte(words[1][15:8]);
    in_valid = 1'b0;
    check("pre_reset_pending", 32'(sb.size()), 32'd0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    reset_n = 1'b1;
    idle(10);
    check("abort_busy", 32'(busy), 32'd0);

    load(2, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
